// File: rtl/gate_pipe.sv
// gate_pipe: registered bitwise gate unit with a 2-entry output FIFO.
//
// Applies one of eight logic operations to two WIDTH-bit operands at the push
// edge and queues the result with its all-zero / all-one flags. Valid/ready
// handshakes on both sides; counts delivered results.
//
// Parameters:
//   WIDTH  operand/result width (>= 1)
//   CNT_W  width of the delivered-result counter
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake; op, a, b sampled on push
//   out_valid / out_ready output handshake
//   out_data              head result (0 when empty)
//   out_zero, out_ones    head result all zeros / all ones (0 when empty)
//   out_par               even parity of head result (GATE_PARITY_EN only)
//   done_cnt              results delivered, modulo 2^CNT_W
//
// Optional feature macro: GATE_PARITY_EN adds the out_par port and one parity
// bit per FIFO entry.
module gate_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_ones,
`ifdef GATE_PARITY_EN
  output logic             out_par,
`endif
  output logic [CNT_W-1:0] done_cnt
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             ones;
`ifdef GATE_PARITY_EN
    logic             par;
`endif
  } entry_t;

  entry_t           head_q, head_d;
  entry_t           tail_q, tail_d;
  entry_t           new_entry;
  logic [1:0]       occ_q, occ_d;
  logic             live_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] res;
  logic             push, pop;

  always_comb begin
    res = '0;
    case (op)
      3'd0:    res = a & b;
      3'd1:    res = ~(a & b);
      3'd2:    res = a | b;
      3'd3:    res = ~(a | b);
      3'd4:    res = a ^ b;
      3'd5:    res = ~(a ^ b);
      3'd6:    res = ~a;
      default: res = a;
    endcase
  end

  always_comb begin
    new_entry      = '0;
    new_entry.data = res;
    new_entry.zero = (res == '0);
    new_entry.ones = (res == '1);
`ifdef GATE_PARITY_EN
    new_entry.par  = ^res;
`endif
  end

  // live_q keeps in_ready low during reset and for the release cycle, so both
  // handshake signals are decoded from registers only.
  assign in_ready  = live_q & ~occ_q[1];
  assign out_valid = (occ_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = new_entry;
        else               tail_d = new_entry;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      // Push implies occ < 2 and pop implies occ > 0, so occ is 1 here.
      2'b11:   head_d = new_entry;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
      live_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      live_q <= 1'b1;
      if (pop) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Head fields are stale after the last pop; gate them with out_valid.
  assign out_data = out_valid ? head_q.data : '0;
  assign out_zero = out_valid & head_q.zero;
  assign out_ones = out_valid & head_q.ones;
`ifdef GATE_PARITY_EN
  assign out_par  = out_valid & head_q.par;
`endif
  assign done_cnt = cnt_q;

endmodule

// File: tb/tb_gate_pipe.sv
// Self-checking bench for gate_pipe (WIDTH=8): directed scenarios plus random
// traffic checked against a queue-based reference model.
module tb_gate_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       op = 3'd0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_ones;
`ifdef GATE_PARITY_EN
  logic             out_par;
`endif
  logic [CNT_W-1:0] done_cnt;

  gate_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_ones  (out_ones),
`ifdef GATE_PARITY_EN
    .out_par   (out_par),
`endif
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of expected results, delivered count, ready enable.
  logic [WIDTH-1:0] exp_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  bit               exp_live = 1'b0;

  function automatic logic [WIDTH-1:0] gate_fn(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    case (o)
      3'd0:    return x & y;
      3'd1:    return ~(x & y);
      3'd2:    return x | y;
      3'd3:    return ~(x | y);
      3'd4:    return x ^ y;
      3'd5:    return ~(x ^ y);
      3'd6:    return ~x;
      default: return x;
    endcase
  endfunction

  function automatic bit model_ready();
    return exp_live && (exp_q.size() < 2);
  endfunction

  task automatic check_outs();
    logic [WIDTH-1:0] h;
    h = (exp_q.size() > 0) ? exp_q[0] : '0;
    check_eq("in_ready", 32'(in_ready), 32'(model_ready()));
    check_eq("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    check_eq("out_data", 32'(out_data), 32'(h));
    check_eq("out_zero", 32'(out_zero), 32'((exp_q.size() > 0) && (h == 8'h00)));
    check_eq("out_ones", 32'(out_ones), 32'((exp_q.size() > 0) && (h == 8'hFF)));
`ifdef GATE_PARITY_EN
    check_eq("out_par", 32'(out_par), 32'((exp_q.size() > 0) && (^h)));
`endif
    check_eq("done_cnt", 32'(done_cnt), 32'(exp_cnt));
  endtask

  // Check current outputs, then advance one clock and update the model.
  task automatic tick();
    bit               push, pop;
    logic [WIDTH-1:0] r;
    check_outs();
    push = rst_n && in_valid && model_ready();
    pop  = rst_n && (exp_q.size() > 0) && out_ready;
    r    = gate_fn(op, a, b);
    @(posedge clk);
    if (rst_n) begin
      if (pop) begin
        void'(exp_q.pop_front());
        exp_cnt++;
      end
      if (push) exp_q.push_back(r);
      exp_live = 1'b1;
    end
    #1;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    exp_q.delete();
    exp_cnt  = '0;
    exp_live = 1'b0;
    #1;
  endtask

  logic [CNT_W-1:0] cnt_before;

  initial begin
    // Reset held for 3 cycles with in_valid high.
    assert_reset();
    in_valid = 1'b1;
    a = 8'h55;
    b = 8'hAA;
    repeat (3) tick();
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_done_cnt", 32'(done_cnt), 32'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick();
    check_eq("rel_in_ready", 32'(in_ready), 32'd1);

    // Op sweep.
    out_ready = 1'b1;
    a = 8'hC5;
    b = 8'h3A;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op = 3'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    check_eq("sweep_cnt", 32'(done_cnt), 32'd8);

    // Back-pressure: third push must be refused.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op = 3'(i + 4);
      a  = 8'(8'h10 + i);
      b  = 8'h0F;
      tick();
    end
    check_eq("bp_in_ready", 32'(in_ready), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    check_eq("bp_cnt", 32'(done_cnt), 32'd10);

    // Simultaneous push and pop at occupancy 1.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op = 3'd2;
    a  = 8'h01;
    b  = 8'h02;
    tick();
    cnt_before = done_cnt;
    out_ready = 1'b1;
    op = 3'd7;
    a  = 8'hA5;
    tick();
    check_eq("sim_valid", 32'(out_valid), 32'd1);
    check_eq("sim_ready", 32'(in_ready), 32'd1);
    check_eq("sim_data", 32'(out_data), 32'h0A5);
    check_eq("sim_cnt", 32'(done_cnt), 32'(cnt_before + 16'd1));
    in_valid = 1'b0;
    tick();

    // Mid-stream reset with 2 entries stored.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op = 3'd6;
    repeat (2) tick();
    in_valid = 1'b0;
    check_eq("mid_full", 32'(out_valid), 32'd1);
    assert_reset();
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();
    check_eq("mid_valid", 32'(out_valid), 32'd0);
    check_eq("mid_cnt", 32'(done_cnt), 32'd0);

`ifdef GATE_PARITY_EN
    in_valid = 1'b1;
    op = 3'd7;
    a  = 8'h07;
    b  = 8'hFF;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check_eq("par_op7", 32'(out_par), 32'd1);
    out_ready = 1'b1;
    tick();
`endif

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      op = 3'($urandom);
      a  = 8'($urandom);
      b  = 8'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        assert_reset();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/gate_pipe.md
# gate_pipe

Parametrised, registered bitwise gate unit: applies one of eight logic operations to two WIDTH-bit operands and returns each result through a 2-entry output FIFO with valid/ready handshakes on both sides. It is the next generation of the team's single-bit combinational NAND gate, and it sits between any producer and consumer of operand pairs that need back-pressure. It also counts delivered results and flags all-zero and all-one results.

## Interface
- WIDTH, 8: operand and result width in bits; must be at least 1.
- CNT_W, 16: width of the delivered-result counter.
- clk  in  1  sole clock; every register updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair and opcode present.
- in_ready  out  1  block can accept this cycle.
- op  in  3  operation: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A, 7 PASS A.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; ignored for op 6 and op 7.
- out_valid  out  1  head FIFO entry valid.
- out_ready  in  1  consumer takes the head entry.
- out_data  out  WIDTH  head result.
- out_zero  out  1  head result is all zeros.
- out_ones  out  1  head result is all ones.
- out_par  out  1  even parity (XOR reduction) of head result; present only with GATE_PARITY_EN.
- done_cnt  out  CNT_W  number of results delivered, modulo 2^CNT_W.

## Operation
- Push: when in_valid and in_ready are both high at the edge, the result f(op,a,b) and its flags are computed from the inputs that cycle and written to the FIFO tail. op travels with the data and no op state is held.
- Pop: when out_valid and out_ready are both high at the edge, the head entry is removed and done_cnt increments by 1. The counter wraps from 2^CNT_W-1 to 0.
- Occupancy: 0, 1 or 2.
  - in_ready = (occupancy < 2) and not in reset.
  - out_valid = (occupancy > 0).
  - Both signals are decoded from registers only. There is no combinational path from out_ready to in_ready.
- Simultaneous push and pop:
  - At occupancy 1: occupancy stays 1, the new entry becomes head on the next cycle, and the counter increments.
  - At occupancy 0: a pop is impossible because out_valid is 0.
  - At occupancy 2: a push is impossible because in_ready is 0, so the pop alone takes occupancy to 1.
- out_data, out_zero, out_ones and out_par are driven from the head entry. When out_valid is 0 they are 0.
- out_zero and out_ones are mutually exclusive for WIDTH ≥ 2. For WIDTH = 1 exactly one of them is high whenever out_valid is high.
- Holding: while out_valid is high and out_ready is low, the head entry and out_data stay unchanged.
- Reset (asserting or mid-operation): FIFO emptied, and any in-flight or stored entries are discarded without being counted.
  - Reset values: in_ready 0, out_valid 0, out_data 0, out_zero 0, out_ones 0, out_par 0, done_cnt 0.
  - in_ready rises in the first cycle after rst_n deasserts.

## Timing
- Latency: result visible on out_data one cycle after the push edge. With out_ready held high, the sustained rate is one result per cycle.
- The FIFO is exactly 2 entries. After 2 pushes with no pop, in_ready drops in the following cycle. It recovers one cycle after the first pop.
- Inputs are sampled only at a push edge. a, b and op may change freely at other times.
- Outputs change only on clock edges or asynchronously on reset assertion.

## Configuration
- GATE_PARITY_EN defined: out_par port exists. Each FIFO entry stores one extra parity bit computed at push, and out_par follows the head like the other flags.
- GATE_PARITY_EN undefined: no out_par port and no parity storage. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8.
- Reset behaviour: hold rst_n low for 3 cycles with in_valid=1. Required: in_ready=0, out_valid=0, done_cnt=0. After release, in_ready=1 one cycle later.
- Op sweep: a=8'hC5, b=8'h3A, out_ready=1, ops 0..7 back to back. Required results in order: 00, FF, FF, 00, FF, 00, 3A, C5, one per cycle. out_zero is high on 00 and out_ones is high on FF. done_cnt reads 8 after the last result.
- Back-pressure: out_ready=0, push three pairs. Required: in_ready=0 after the second push and the third push is not accepted. Raising out_ready then delivers the first two results in order, with no loss or duplication.
- Simultaneous push and pop at occupancy 1: the pushed and popped entries are both handled on the same edge. Required: occupancy stays 1 and done_cnt increments by exactly 1.
- Mid-stream reset: with 2 entries stored, pulse rst_n low for 1 cycle. Required: FIFO empty, done_cnt=0, and the stored results are never output.
- Parity: with GATE_PARITY_EN defined, op 7 with a=8'h07. Required: out_par=1. Rerun the whole bench without the macro: it compiles and every other check passes.
